// File: rtl/instr_fetch_seq_pkg.sv
// Shared constants for the 4-bit instruction fetch sequencer: phase encoding,
// two-word opcode values and the two-word decode used by the sequencer.
package instr_fetch_seq_pkg;

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_t;

  localparam int PC_W = 12;

  localparam logic [3:0] OPC_JCN = 4'h1;
  localparam logic [3:0] OPC_FIM = 4'h2;
  localparam logic [3:0] OPC_JUN = 4'h4;
  localparam logic [3:0] OPC_JMS = 4'h5;
  localparam logic [3:0] OPC_ISZ = 4'h7;

  // FIM and SRC share opcode 2; only the even-operand form (FIM) carries a second word.
  function automatic logic is_two_word(input logic [3:0] opr, input logic [3:0] opa);
    logic two;
    two = 1'b0;
    case (opr)
      OPC_JCN, OPC_JUN, OPC_JMS, OPC_ISZ: two = 1'b1;
      OPC_FIM:                            two = ~opa[0];
      default:                            two = 1'b0;
    endcase
    return two;
  endfunction

endpackage

// File: rtl/instr_fetch_seq_if.sv
// Bus bundle between the fetch sequencer (slave) and its ROM/CPU environment (master).
// There is no valid/ready handshake: every transfer is timed by the 8-phase cycle counter.
interface instr_fetch_seq_if;
  logic [3:0]  romData;
  logic        jumpEn;
  logic [11:0] jumpAddr;
  logic [2:0]  cycle;
  logic        sync;
  logic [3:0]  addrOut;
  logic        addrOe;
  logic [3:0]  opr;
  logic [3:0]  opa;
  logic        secondWord;
  logic [7:0]  operand2;
  logic [11:0] pc;

  modport master (
    output romData, jumpEn, jumpAddr,
    input  cycle, sync, addrOut, addrOe, opr, opa, secondWord, operand2, pc
  );

  modport slave (
    input  romData, jumpEn, jumpAddr,
    output cycle, sync, addrOut, addrOe, opr, opa, secondWord, operand2, pc
  );
endinterface

// File: rtl/instr_fetch_seq_pc_reg.sv
// 12-bit program counter: on a step it either loads a target or increments,
// wrapping 12'hFFF to 12'h000.
module pc_reg
  import instr_fetch_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rstN,
  input  logic            i_step,
  input  logic            i_load,
  input  logic [PC_W-1:0] i_load_addr,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_pc <= '0;
    end else if (i_step) begin
      r_pc <= i_load ? i_load_addr : r_pc + 12'd1;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch_seq.sv
// Eight-phase instruction fetch sequencer: drives the PC out in A1..A3, latches
// opcode/operand in M1/M2 and tracks the second word of two-word instructions.
module instr_fetch_seq
  import instr_fetch_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rstN,
  instr_fetch_seq_if.slave  bus
);

  phase_t          r_cycle;
  phase_t          w_cycle_nxt;
  logic            w_sync;
  logic            w_addr_oe;
  logic [3:0]      w_addr_out;
  logic            w_at_m1;
  logic            w_at_m2;
  logic            w_at_x3;
  logic [PC_W-1:0] w_pc;

  logic [3:0]      r_holding;
  logic [3:0]      r_opr;
  logic [3:0]      r_opa;
  logic            r_second;
  logic [7:0]      r_operand2;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_cycle <= PH_A1;
    end else begin
      r_cycle <= w_cycle_nxt;
    end
  end

  // The phase counter is a free-running ring; X3 wraps naturally to A1.
  always_comb begin
    w_cycle_nxt = phase_t'(r_cycle + 3'd1);
    w_sync      = 1'b0;
    w_addr_oe   = 1'b0;
    w_addr_out  = 4'h0;
    w_at_m1     = 1'b0;
    w_at_m2     = 1'b0;
    w_at_x3     = 1'b0;
    case (r_cycle)
      PH_A1: begin w_addr_oe = 1'b1; w_addr_out = w_pc[3:0];  end
      PH_A2: begin w_addr_oe = 1'b1; w_addr_out = w_pc[7:4];  end
      PH_A3: begin w_addr_oe = 1'b1; w_addr_out = w_pc[11:8]; end
      PH_M1: w_at_m1 = 1'b1;
      PH_M2: w_at_m2 = 1'b1;
      PH_X3: begin w_sync = 1'b1; w_at_x3 = 1'b1; end
      default: ;
    endcase
  end

  // During a second-word cycle the M1/M2 nibbles go to operand2 and opr/opa are frozen.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_holding  <= 4'h0;
      r_opr      <= 4'h0;
      r_opa      <= 4'h0;
      r_second   <= 1'b0;
      r_operand2 <= 8'h00;
    end else begin
      if (w_at_m1) begin
        r_holding <= bus.romData;
      end
      if (w_at_m2) begin
        if (r_second) begin
          r_operand2 <= {r_holding, bus.romData};
        end else begin
          r_opr <= r_holding;
          r_opa <= bus.romData;
        end
      end
      if (w_at_x3) begin
        r_second <= ~r_second & is_two_word(r_opr, r_opa);
      end
    end
  end

  pc_reg u_pc_reg (
    .clk         (clk),
    .rstN        (rstN),
    .i_step      (w_at_x3),
    .i_load      (bus.jumpEn),
    .i_load_addr (bus.jumpAddr),
    .o_pc        (w_pc)
  );

  assign bus.cycle      = r_cycle;
  assign bus.sync       = w_sync;
  assign bus.addrOut    = w_addr_out;
  assign bus.addrOe     = w_addr_oe;
  assign bus.opr        = r_opr;
  assign bus.opa        = r_opa;
  assign bus.secondWord = r_second;
  assign bus.operand2   = r_operand2;
  assign bus.pc         = w_pc;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Bench for instr_fetch_seq: directed instruction cycles with hand-computed
// per-cycle expectations, checked at X1 by an independent monitor.
module tb_instr_fetch_seq;
  import instr_fetch_seq_pkg::*;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_seq_if bus();

  instr_fetch_seq dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  // Expectation record: {pc[11:0], opr[3:0], opa[3:0], secondWord, operand2[7:0]}
  logic [28:0] exp_q[$];
  logic [2:0]  exp_cycle;
  logic [3:0]  addr_cap [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [11:0] pc, input logic [3:0] opr, input logic [3:0] opa,
                          input logic sw, input logic [7:0] op2);
    exp_q.push_back({pc, opr, opa, sw, op2});
  endtask

  // Starts in A1 just after the edge that entered it; returns at the next A1.
  task automatic do_instr(input logic [3:0] m1, input logic [3:0] m2, input logic je,
                          input logic [11:0] ja, input logic je_m1);
    for (int p = 0; p < 8; p++) begin
      bus.romData  = (p == 3) ? m1 : (p == 4) ? m2 : 4'($urandom_range(0, 15));
      bus.jumpEn   = (p == 7) ? je : (p == 3) ? je_m1 : 1'b0;
      bus.jumpAddr = (p == 7 || p == 3) ? ja : 12'($urandom_range(0, 4095));
      @(posedge clk);
      #1;
    end
  endtask

  always @(posedge clk or negedge rstN) begin
    if (!rstN) exp_cycle <= 3'd0;
    else       exp_cycle <= exp_cycle + 3'd1;
  end

  // Monitor
  always @(negedge clk) begin
    logic [28:0] e;
    if (rstN) begin
      check("cycle", 32'(bus.cycle), 32'(exp_cycle));
      check("sync", 32'(bus.sync), 32'(exp_cycle == 3'd7));
      check("addrOe", 32'(bus.addrOe), 32'(exp_cycle < 3'd3));
      if (exp_cycle < 3'd3) addr_cap[exp_cycle] = bus.addrOut;
      else check("addrOut_idle", 32'(bus.addrOut), 32'h0);
      if (exp_cycle == 3'd5) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL monitor: X1 reached with no expectation queued at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("pc", 32'(bus.pc), 32'(e[28:17]));
          check("addrOut_A1A2A3", 32'({addr_cap[2], addr_cap[1], addr_cap[0]}), 32'(e[28:17]));
          check("opr", 32'(bus.opr), 32'(e[16:13]));
          check("opa", 32'(bus.opa), 32'(e[12:9]));
          check("secondWord", 32'(bus.secondWord), 32'(e[8]));
          check("operand2", 32'(bus.operand2), 32'(e[7:0]));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.romData  = 4'h0;
    bus.jumpEn   = 1'b0;
    bus.jumpAddr = 12'h000;
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.romData  = 4'hF;
    bus.jumpEn   = 1'b1;
    bus.jumpAddr = 12'hABC;
    #1;
    check("rst_cycle", 32'(bus.cycle), 32'h0);
    check("rst_pc", 32'(bus.pc), 32'h0);
    check("rst_opr", 32'(bus.opr), 32'h0);
    check("rst_opa", 32'(bus.opa), 32'h0);
    check("rst_operand2", 32'(bus.operand2), 32'h0);
    check("rst_secondWord", 32'(bus.secondWord), 32'h0);
    check("rst_sync", 32'(bus.sync), 32'h0);
    check("rst_addrOe", 32'(bus.addrOe), 32'h1);
    check("rst_addrOut", 32'(bus.addrOut), 32'h0);
    bus.jumpEn = 1'b0;
    @(posedge clk);
    #1;
    rstN = 1'b1;

    push_exp(12'h000, 4'h0, 4'h0, 1'b0, 8'h00); do_instr(4'h0, 4'h0, 1'b1, 12'h3A5, 1'b0);
    push_exp(12'h3A5, 4'hA, 4'h3, 1'b0, 8'h00); do_instr(4'hA, 4'h3, 1'b0, 12'h000, 1'b0);
    push_exp(12'h3A6, 4'h4, 4'h0, 1'b0, 8'h00); do_instr(4'h4, 4'h0, 1'b0, 12'h000, 1'b0);
    push_exp(12'h3A7, 4'h4, 4'h0, 1'b1, 8'h2F); do_instr(4'h2, 4'hF, 1'b0, 12'h000, 1'b0);
    push_exp(12'h3A8, 4'h2, 4'h4, 1'b0, 8'h2F); do_instr(4'h2, 4'h4, 1'b0, 12'h555, 1'b1);
    push_exp(12'h3A9, 4'h2, 4'h4, 1'b1, 8'h17); do_instr(4'h1, 4'h7, 1'b1, 12'h120, 1'b0);
    push_exp(12'h120, 4'h2, 4'h5, 1'b0, 8'h17); do_instr(4'h2, 4'h5, 1'b1, 12'hFFF, 1'b0);
    push_exp(12'hFFF, 4'hA, 4'h3, 1'b0, 8'h17); do_instr(4'hA, 4'h3, 1'b0, 12'h000, 1'b0);
    push_exp(12'h000, 4'h5, 4'h0, 1'b0, 8'h17); do_instr(4'h5, 4'h0, 1'b1, 12'h200, 1'b0);
    push_exp(12'h200, 4'h5, 4'h0, 1'b1, 8'hCD); do_instr(4'hC, 4'hD, 1'b0, 12'h000, 1'b0);
    push_exp(12'h201, 4'h7, 4'h1, 1'b0, 8'hCD); do_instr(4'h7, 4'h1, 1'b0, 12'h000, 1'b0);

    // Second-word cycle at 12'h202, aborted by reset in M1
    for (int p = 0; p < 3; p++) begin
      bus.romData = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
    end
    check("pre_abort_cycle", 32'(bus.cycle), 32'h3);
    check("pre_abort_secondWord", 32'(bus.secondWord), 32'h1);
    check("pre_abort_pc", 32'(bus.pc), 32'h202);
    bus.romData = 4'h9;
    rstN = 1'b0;
    #1;
    check("abort_cycle", 32'(bus.cycle), 32'h0);
    check("abort_pc", 32'(bus.pc), 32'h0);
    check("abort_opr", 32'(bus.opr), 32'h0);
    check("abort_opa", 32'(bus.opa), 32'h0);
    check("abort_operand2", 32'(bus.operand2), 32'h0);
    check("abort_secondWord", 32'(bus.secondWord), 32'h0);
    check("abort_sync", 32'(bus.sync), 32'h0);
    check("abort_addrOe", 32'(bus.addrOe), 32'h1);
    check("abort_addrOut", 32'(bus.addrOut), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rstN = 1'b1;

    push_exp(12'h000, 4'hA, 4'h3, 1'b0, 8'h00); do_instr(4'hA, 4'h3, 1'b0, 12'h000, 1'b0);
    push_exp(12'h001, 4'h0, 4'h0, 1'b0, 8'h00); do_instr(4'h0, 4'h0, 1'b0, 12'h000, 1'b0);

    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_seq.md
INSTR_FETCH_SEQ -- requirements
Module: instr_fetch_seq

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single system clock; all state changes on rising edge.
REQ-002 The block SHALL have port rstN, input, 1 bit: asynchronous active-low reset.
REQ-003 The block SHALL have port romData, input, 4 bits: ROM nibble, sampled at M1/M2.
REQ-004 The block SHALL have port jumpEn, input, 1 bit: load PC from jumpAddr at X3.
REQ-005 The block SHALL have port jumpAddr, input, 12 bits: jump target.
REQ-006 The block SHALL have port cycle, output, 3 bits: current phase, A1=0 A2=1 A3=2 M1=3 M2=4 X1=5 X2=6 X3=7.
REQ-007 The block SHALL have port sync, output, 1 bit: high while cycle==X3, marking instruction-cycle boundary.
REQ-008 The block SHALL have port addrOut, output, 4 bits: PC nibble driven during A1..A3.
REQ-009 The block SHALL have port addrOe, output, 1 bit: high during A1..A3 only.
REQ-010 The block SHALL have port opr, output, 4 bits: latched opcode of current instruction.
REQ-011 The block SHALL have port opa, output, 4 bits: latched operand of current instruction.
REQ-012 The block SHALL have port secondWord, output, 1 bit: current instruction cycle fetches the second word of a two-word instruction.
REQ-013 The block SHALL have port operand2, output, 8 bits: second word {M1 nibble, M2 nibble}.
REQ-014 The block SHALL have port pc, output, 12 bits: program counter.

Function
REQ-015 cycle SHALL increment by 1 every clk and wrap 7->0.
REQ-016 addrOut SHALL equal pc[3:0] in A1, pc[7:4] in A2, pc[11:8] in A3, and 4'h0 otherwise.
REQ-017 In a first-word cycle, romData at M1 SHALL be captured into a holding register, and at M2 opr<=holding and opa<=romData, both visible from X1.
REQ-018 opr/opa SHALL remain stable from X1 until the next first-word M2 edge.
REQ-019 A first word SHALL be two-word when opr is 1 (JCN), 4 (JUN), 5 (JMS), 7 (ISZ), or 2 with opa[0]=0 (FIM); secondWord SHALL then be set at the following X3 edge for exactly one instruction cycle.
REQ-020 During a secondWord cycle, opr/opa SHALL NOT change, and operand2 SHALL load {M1 nibble, M2 nibble}, updating at M2.
REQ-021 At each X3 edge, pc SHALL load jumpAddr if jumpEn=1, else pc+1 modulo 4096 (12'hFFF -> 12'h000).
REQ-022 jumpEn SHALL be ignored outside X3.
REQ-023 A jump at the X3 ending a secondWord cycle SHALL clear secondWord normally; a jump at the X3 ending a two-word first word SHALL still set secondWord.
REQ-024 sync SHALL be combinational from cycle, with no added latency.

Reset
REQ-025 While rstN=0, the block SHALL hold cycle=0, pc=0, opr=0, opa=0, operand2=0, secondWord=0, and holding=0, which makes sync=0, addrOe=1, and addrOut=0.
REQ-026 A reset asserted mid-cycle SHALL abort the fetch immediately, discard partial opcode and second-word data, and on release restart at A1 with pc=0.

Structure
REQ-027 A shared package SHALL hold cycle phase constants A1..X3 and 4-bit opcode constants (JCN, FIM, JUN, JMS, ISZ); the decoder SHALL use the same package.
REQ-028 The 12-bit PC SHALL be a single sub-module, pc_reg, with increment/load/wrap; all other logic SHALL be in instr_fetch_seq.

Verification
REQ-029 Verification SHALL cover reset release: cycle SHALL read 0,1,...,7,0; sync SHALL be high only at 7; addrOut SHALL read 0,0,0 in A1..A3.
REQ-030 Verification SHALL cover a single-word fetch: pc=12'h3A5 and romData=4'hA at M1, 4'h3 at M2, SHALL give addrOut 5,A,3, then opr=A and opa=3 from X1, secondWord=0, and pc=12'h3A6 after X3.
REQ-031 Verification SHALL cover a two-word fetch: romData 4/0 (JUN) then 2/F in the next cycle SHALL give secondWord=1 for one cycle, opr=4 held, and operand2=8'h2F.
REQ-032 Verification SHALL cover the FIM/SRC split: opr=2 with opa=4 SHALL set secondWord, while opr=2 with opa=5 SHALL NOT.
REQ-033 Verification SHALL cover jump and wrap: jumpEn=1 with jumpAddr=12'h120 at X3 SHALL give pc=12'h120; jumpEn pulsed at M1 SHALL have no effect; pc=12'hFFF SHALL increment to 12'h000.
REQ-034 Verification SHALL cover mid-operation reset: rstN low at M1 of a second-word cycle SHALL clear all outputs immediately, and after release the first fetch SHALL be a first word at pc=0.
